// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver, optional parity check enabled by defining PARITY_RX_EN
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST = 4'(DATA_BITS - 1);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] PARITY  = 3'd3;
  localparam logic [2:0] STOP    = 3'd4;
  localparam logic [2:0] RECOVER = 3'd5;
`ifdef PARITY_RX_EN
  localparam logic [2:0] AFTER_DATA = PARITY;
  logic par;
`else
  localparam logic [2:0] AFTER_DATA = STOP;
`endif
  if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || OVERSAMPLE % 2 != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_rx: illegal parameter value");
  end
  logic [2:0]           state;
  logic                 rx_m, rx_s;
  logic [CW-1:0]        cnt;
  logic [3:0]           idx;
  logic [DATA_BITS-1:0] sh;
  logic                 half, full;
  assign half = baud_tick && cnt == HALF;
  assign full = baud_tick && cnt == FULL;
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
`ifdef PARITY_RX_EN
      par        <= 1'b0;
`endif
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= state != IDLE;
      if (baud_tick && state != IDLE) cnt <= cnt + 1'b1;
      case (state)
        IDLE: if (baud_tick && !rx_s) begin
          state <= START;
          cnt   <= '0;
        end
        START: if (half) begin
          state <= rx_s ? IDLE : DATA;
          cnt   <= '0;
          idx   <= '0;
        end
        DATA: if (full) begin
          sh  <= {rx_s, sh[DATA_BITS-1:1]};
          idx <= idx + 1'b1;
          cnt <= '0;
          if (idx == LAST) state <= AFTER_DATA;
        end
`ifdef PARITY_RX_EN
        PARITY: if (full) begin
          par   <= rx_s;
          state <= STOP;
          cnt   <= '0;
        end
`endif
        STOP: if (full) begin
          rx_data    <= sh;
          rx_valid   <= 1'b1;
          frame_err  <= !rx_s;
`ifdef PARITY_RX_EN
          parity_err <= ((^sh) ^ 1'(PARITY_ODD)) != par;
`endif
          state      <= rx_s ? IDLE : RECOVER;
          cnt        <= '0;
        end
        RECOVER: if (baud_tick && rx_s) begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus checked against a queue-based receiver model
module tb_uart_rx;
  localparam int PODD = 0;
`ifdef PARITY_RX_EN
  localparam bit PE_EN = 1'b1;
`else
  localparam bit PE_EN = 1'b0;
`endif
  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;
  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, busy;
  exp_t       q[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  int         vcnt = 0;
  int         bc = 0;
  logic [7:0] cur_data = 8'h00;
  logic       last_fe = 1'b0;
  logic       last_pe = 1'b0;
  logic       bexp = 1'b0;
  logic       prev_valid = 1'b0;
  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_ODD(PODD)) dut (
    .clk_in(clk_in), .rst(rst), .baud_tick(baud_tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy)
  );
  always #5 clk_in = ~clk_in;
  initial forever begin
    baud_tick = 1'b0;
    repeat (3) @(negedge clk_in);
    baud_tick = 1'b1;
    @(negedge clk_in);
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ 1'(PODD);
  endfunction
  task automatic hold(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk_in);
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input logic pbit);
    exp_t x;
    x.d  = d;
    x.fe = !stop;
    x.pe = PE_EN && (pbit != good_par(d));
    q.push_back(x);
    hold(1'b0, 64);
    for (int i = 0; i < 8; i++) hold(d[i], 64);
    if (PE_EN) hold(pbit, 64);
    hold(stop, 64);
  endtask
  always @(negedge clk_in) begin
    if (rst) begin
      bc = 0;
      prev_valid = 1'b0;
    end else begin
      if (rx_valid) begin
        vcnt++;
        last_fe = frame_err;
        last_pe = parity_err;
        if (q.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          e = q.pop_front();
          cur_data = e.d;
          chk("frame_err", int'(frame_err), int'(e.fe));
          chk("parity_err", int'(parity_err), int'(e.pe));
          bc = 2;
          bexp = e.fe;
        end
      end else chk("err_without_valid", int'({frame_err, parity_err}), 0);
      chk("valid_pulse_width", int'(prev_valid & rx_valid), 0);
      prev_valid = rx_valid;
      chk("rx_data", int'(rx_data), int'(cur_data));
      if (bc > 0) begin
        bc--;
        if (bc == 0) chk("busy_after_valid", int'(busy), int'(bexp));
      end
    end
  end
  initial begin
    int v0, n, r;
    logic saw;
    logic [7:0] d;
    repeat (5) @(negedge clk_in);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_parity_err", int'(parity_err), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    hold(1'b1, 100);
    v0 = vcnt;
    send(8'hA5, 1'b1, good_par(8'hA5));
    hold(1'b1, 64);
    chk("a5_valid_count", vcnt - v0, 1);
    chk("a5_data", int'(rx_data), 'hA5);
    chk("a5_frame_err", int'(last_fe), 0);
    v0 = vcnt;
    saw = 1'b0;
    rx = 1'b0;
    repeat (16) begin @(negedge clk_in); saw |= busy; end
    rx = 1'b1;
    repeat (64) begin @(negedge clk_in); saw |= busy; end
    chk("glitch_busy_seen", int'(saw), 1);
    chk("glitch_busy_idle", int'(busy), 0);
    chk("glitch_no_valid", vcnt - v0, 0);
    send(8'h3C, 1'b1, good_par(8'h3C));
    hold(1'b1, 64);
    chk("post_glitch_data", int'(rx_data), 'h3C);
    v0 = vcnt;
    send(8'h3C, 1'b0, good_par(8'h3C));
    rx = 1'b0;
    n = 0;
    repeat (200) begin @(negedge clk_in); if (!busy) n++; end
    chk("busy_held_low", n, 0);
    rx = 1'b1;
    n = 0;
    while (busy && n < 20) begin @(negedge clk_in); n++; end
    chk("busy_release", int'(busy), 0);
    hold(1'b1, 64);
    chk("ferr_valid_count", vcnt - v0, 1);
    chk("ferr_flag", int'(last_fe), 1);
    chk("ferr_data", int'(rx_data), 'h3C);
    v0 = vcnt;
    send(8'h00, 1'b1, good_par(8'h00));
    send(8'hFF, 1'b1, good_par(8'hFF));
    hold(1'b1, 64);
    chk("b2b_valid_count", vcnt - v0, 2);
    chk("b2b_data", int'(rx_data), 'hFF);
    chk("b2b_frame_err", int'(last_fe), 0);
    v0 = vcnt;
    hold(1'b0, 64);
    hold(1'b1, 64);
    hold(1'b0, 64);
    hold(1'b0, 64);
    hold(1'b0, 30);
    #2 rst = 1'b1;
    #1;
    chk("abort_rx_data", int'(rx_data), 0);
    chk("abort_rx_valid", int'(rx_valid), 0);
    chk("abort_frame_err", int'(frame_err), 0);
    chk("abort_busy", int'(busy), 0);
    q.delete();
    cur_data = 8'h00;
    rx = 1'b1;
    repeat (4) @(negedge clk_in);
    rst = 1'b0;
    hold(1'b1, 100);
    chk("abort_no_valid", vcnt - v0, 0);
    send(8'h5A, 1'b1, good_par(8'h5A));
    hold(1'b1, 64);
    chk("after_abort_data", int'(rx_data), 'h5A);
`ifdef PARITY_RX_EN
    send(8'h07, 1'b1, 1'b0);
    hold(1'b1, 64);
    chk("parity_bad", int'(last_pe), 1);
    send(8'h07, 1'b1, 1'b1);
    hold(1'b1, 64);
    chk("parity_good", int'(last_pe), 0);
`endif
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      d = 8'($urandom);
      if (r == 0) begin
        hold(1'b0, $urandom_range(4, 20));
        hold(1'b1, 48);
      end else if (r == 1) begin
        send(d, 1'b0, good_par(d));
        hold(1'b0, $urandom_range(40, 120));
        hold(1'b1, $urandom_range(16, 40));
      end else begin
        send(d, 1'b1, ($urandom_range(0, 3) == 0) ? !good_par(d) : good_par(d));
        n = $urandom_range(0, 40);
        if (n > 0) hold(1'b1, n);
      end
    end
    hold(1'b1, 100);
    chk("pending_frames", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
